// File: rtl/mem_port_arbiter_if.sv
// Request, response and memory-side signals of the unified memory port arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// the hart and memory together.
interface mem_port_arbiter_if;
    // instruction-fetch port
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_ack;
    logic        o_if_rvalid;
    logic [31:0] o_if_rdata;
    logic        o_if_err;
    // data port
    logic        i_d_req;
    logic [31:0] i_d_addr;
    logic        i_d_wen;
    logic [31:0] i_d_wdata;
    logic [3:0]  i_d_mask;
    logic        o_d_ack;
    logic        o_d_rvalid;
    logic [31:0] o_d_rdata;
    logic        o_d_err;
    // memory side
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_mask;
    logic        i_mem_ready;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_ack, o_if_rvalid, o_if_rdata, o_if_err,
        input  i_d_req, i_d_addr, i_d_wen, i_d_wdata, i_d_mask,
        output o_d_ack, o_d_rvalid, o_d_rdata, o_d_err,
        output o_mem_req, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_mask,
        input  i_mem_ready, i_mem_rvalid, i_mem_rdata
    );

    modport master (
        output i_if_req, i_if_addr,
        input  o_if_ack, o_if_rvalid, o_if_rdata, o_if_err,
        output i_d_req, i_d_addr, i_d_wen, i_d_wdata, i_d_mask,
        input  o_d_ack, o_d_rvalid, o_d_rdata, o_d_err,
        input  o_mem_req, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_mask,
        output i_mem_ready, i_mem_rvalid, i_mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the fetch and data ports.
// Data has priority, but a pending fetch is forced through after MAX_DGRANT
// back-to-back data grants. Only one memory transaction is outstanding at a
// time. A transaction that stalls in REQ or WAIT for TIMEOUT cycles is aborted
// and reported to its owner with err set.
module mem_port_arbiter #(
    parameter int unsigned MAX_DGRANT = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    mem_port_arbiter_if.slave  bus
);
    localparam int unsigned DCW = $clog2(MAX_DGRANT + 1);
    localparam int unsigned TW  = $clog2(TIMEOUT + 1);
    localparam logic [DCW-1:0] DMAX = DCW'(MAX_DGRANT);
    localparam logic [TW-1:0]  TLIM = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t         state_q, state_d;
    logic [DCW-1:0] dcount_q, dcount_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           owner_d_q, owner_d_d;      // 1 = data port owns the transaction
    logic [31:0]    mem_addr_q, mem_addr_d;
    logic           mem_wen_q, mem_wen_d;
    logic [31:0]    mem_wdata_q, mem_wdata_d;
    logic [3:0]     mem_mask_q, mem_mask_d;
    logic           if_rvalid_q, if_rvalid_d;
    logic [31:0]    if_rdata_q, if_rdata_d;
    logic           if_err_q, if_err_d;
    logic           d_rvalid_q, d_rvalid_d;
    logic [31:0]    d_rdata_q, d_rdata_d;
    logic           d_err_q, d_err_d;
    logic           if_ack, d_ack, mem_req, grant_d;

    // Grant selection, transaction sequencing, timeout and response generation
    always_comb begin
        state_d     = state_q;
        dcount_d    = dcount_q;
        timer_d     = timer_q;
        owner_d_d   = owner_d_q;
        mem_addr_d  = mem_addr_q;
        mem_wen_d   = mem_wen_q;
        mem_wdata_d = mem_wdata_q;
        mem_mask_d  = mem_mask_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        if_err_d    = 1'b0;
        d_rvalid_d  = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_err_d     = 1'b0;
        if_ack      = 1'b0;
        d_ack       = 1'b0;
        mem_req     = 1'b0;
        grant_d     = bus.i_d_req && !(bus.i_if_req && (dcount_q >= DMAX));

        case (state_q)
            S_IDLE: begin
                if (bus.i_d_req || bus.i_if_req) begin
                    state_d = S_REQ;
                    timer_d = '0;
                    if (grant_d) begin
                        d_ack       = 1'b1;
                        owner_d_d   = 1'b1;
                        mem_addr_d  = bus.i_d_addr;
                        mem_wen_d   = bus.i_d_wen;
                        mem_wdata_d = bus.i_d_wdata;
                        mem_mask_d  = bus.i_d_mask;
                        if (!bus.i_if_req) begin
                            dcount_d = '0;
                        end else if (dcount_q != DMAX) begin
                            dcount_d = dcount_q + 1'b1;
                        end
                    end else begin
                        if_ack      = 1'b1;
                        owner_d_d   = 1'b0;
                        mem_addr_d  = bus.i_if_addr;
                        mem_wen_d   = 1'b0;
                        mem_wdata_d = '0;
                        mem_mask_d  = '1;
                        dcount_d    = '0;
                    end
                end
            end
            S_REQ: begin
                mem_req = 1'b1;
                if (bus.i_mem_ready) begin
                    state_d = S_WAIT;
                    timer_d = '0;
                end else if (timer_q == TLIM) begin
                    state_d = S_IDLE;
                    if (owner_d_q) begin
                        d_rvalid_d = 1'b1;
                        d_err_d    = 1'b1;
                        d_rdata_d  = '0;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_err_d    = 1'b1;
                        if_rdata_d  = '0;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.i_mem_rvalid) begin
                    state_d = S_IDLE;
                    if (owner_d_q) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = mem_wen_q ? '0 : bus.i_mem_rdata;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = bus.i_mem_rdata;
                    end
                end else if (timer_q == TLIM) begin
                    state_d = S_IDLE;
                    if (owner_d_q) begin
                        d_rvalid_d = 1'b1;
                        d_err_d    = 1'b1;
                        d_rdata_d  = '0;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_err_d    = 1'b1;
                        if_rdata_d  = '0;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, latched memory fields and registered responses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            dcount_q    <= '0;
            timer_q     <= '0;
            owner_d_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wen_q   <= 1'b0;
            mem_wdata_q <= '0;
            mem_mask_q  <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            if_err_q    <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            dcount_q    <= dcount_d;
            timer_q     <= timer_d;
            owner_d_q   <= owner_d_d;
            mem_addr_q  <= mem_addr_d;
            mem_wen_q   <= mem_wen_d;
            mem_wdata_q <= mem_wdata_d;
            mem_mask_q  <= mem_mask_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            if_err_q    <= if_err_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
        end
    end

    // Acks are gated by reset so every output is low while reset is held
    assign bus.o_if_ack    = if_ack & i_rst_n;
    assign bus.o_d_ack     = d_ack & i_rst_n;
    assign bus.o_mem_req   = mem_req;
    assign bus.o_mem_addr  = mem_addr_q;
    assign bus.o_mem_wen   = mem_wen_q;
    assign bus.o_mem_wdata = mem_wdata_q;
    assign bus.o_mem_mask  = mem_mask_q;
    assign bus.o_if_rvalid = if_rvalid_q;
    assign bus.o_if_rdata  = if_rdata_q;
    assign bus.o_if_err    = if_err_q;
    assign bus.o_d_rvalid  = d_rvalid_q;
    assign bus.o_d_rdata   = d_rdata_q;
    assign bus.o_d_err     = d_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level model of the grant, field and response rules.
module tb_mem_port_arbiter;
    localparam int unsigned MAXD = 4;
    localparam int unsigned TMO  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.MAX_DGRANT(MAXD), .TIMEOUT(TMO)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // model: pending requests and consecutive-data-grant streak
    bit          if_pend = 1'b0;
    logic [31:0] if_a    = '0;
    bit          d_pend  = 1'b0;
    logic [31:0] d_a     = '0;
    bit          d_w     = 1'b0;
    logic [31:0] d_wd    = '0;
    logic [3:0]  d_m     = '0;
    int          m_streak = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        bus.i_if_req   = if_pend;
        bus.i_if_addr  = if_a;
        bus.i_d_req    = d_pend;
        bus.i_d_addr   = d_a;
        bus.i_d_wen    = d_w;
        bus.i_d_wdata  = d_wd;
        bus.i_d_mask   = d_m;
    endtask

    task automatic new_d();
        d_pend = 1'b1;
        d_a    = $urandom;
        d_w    = 1'($urandom_range(0, 1));
        d_wd   = $urandom;
        d_m    = 4'($urandom_range(1, 15));
    endtask

    task automatic new_if();
        if_pend = 1'b1;
        if_a    = $urandom;
    endtask

    task automatic advance();
        @(negedge clk);
    endtask

    // idle cycles: nothing may be acked, requested or returned
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            advance();
            #1;
            chk("idle_if_ack", 32'(bus.o_if_ack), 32'(0));
            chk("idle_d_ack", 32'(bus.o_d_ack), 32'(0));
            chk("idle_mem_req", 32'(bus.o_mem_req), 32'(0));
            chk("idle_if_rvalid", 32'(bus.o_if_rvalid), 32'(0));
            chk("idle_d_rvalid", 32'(bus.o_d_rvalid), 32'(0));
        end
    endtask

    // One complete transaction, starting in an IDLE cycle whose requests are
    // already driven, and ending (without advancing) in the response cycle.
    // rdly/vdly: cycles before ready/rvalid; >= TMO means never (timeout).
    task automatic do_txn(input int rdly, input int vdly, input logic [31:0] mdata,
                          input bit refill_if, input bit refill_d, output bit got_d);
        bit          exp_d, exp_store, aborted;
        logic [31:0] ea, ewd, erd;
        logic [3:0]  em;
        bit          ew;
        #1;
        exp_d = d_pend && !(if_pend && m_streak >= int'(MAXD));
        chk("grant_d_ack", 32'(bus.o_d_ack), 32'(exp_d));
        chk("grant_if_ack", 32'(bus.o_if_ack), 32'(!exp_d));
        if (exp_d) begin
            ea = d_a; ew = d_w; ewd = d_wd; em = d_m;
            m_streak = if_pend ? m_streak + 1 : 0;
        end else begin
            ea = if_a; ew = 1'b0; ewd = '0; em = 4'hF;
            m_streak = 0;
        end
        exp_store = exp_d && ew;
        got_d = exp_d;
        advance();
        if (exp_d) begin
            d_pend = 1'b0;
            if (refill_d) new_d();
        end else begin
            if_pend = 1'b0;
            if (refill_if) new_if();
        end
        drive_reqs();
        aborted = (rdly >= int'(TMO));
        for (int k = 0; k < int'(TMO); k++) begin
            bus.i_mem_ready = (k == rdly);
            #1;
            chk("req_mem_req", 32'(bus.o_mem_req), 32'(1));
            chk("req_mem_addr", bus.o_mem_addr, ea);
            chk("req_mem_wen", 32'(bus.o_mem_wen), 32'(ew));
            chk("req_mem_wdata", bus.o_mem_wdata, ewd);
            chk("req_mem_mask", 32'(bus.o_mem_mask), 32'(em));
            chk("req_acks", 32'({bus.o_if_ack, bus.o_d_ack}), 32'(0));
            advance();
            if (k == rdly) break;
        end
        bus.i_mem_ready = 1'b0;
        if (!aborted) begin
            aborted = (vdly >= int'(TMO));
            for (int k = 0; k < int'(TMO); k++) begin
                bus.i_mem_rvalid = (k == vdly);
                bus.i_mem_rdata  = (k == vdly) ? mdata : $urandom;
                #1;
                chk("wait_mem_req", 32'(bus.o_mem_req), 32'(0));
                chk("wait_acks", 32'({bus.o_if_ack, bus.o_d_ack}), 32'(0));
                chk("wait_rvalids", 32'({bus.o_if_rvalid, bus.o_d_rvalid}), 32'(0));
                advance();
                if (k == vdly) break;
            end
        end
        bus.i_mem_rvalid = 1'b0;
        #1;
        erd = (aborted || exp_store) ? 32'h0 : mdata;
        chk("rsp_d_rvalid", 32'(bus.o_d_rvalid), 32'(exp_d));
        chk("rsp_if_rvalid", 32'(bus.o_if_rvalid), 32'(!exp_d));
        chk("rsp_mem_req", 32'(bus.o_mem_req), 32'(0));
        if (exp_d) begin
            chk("rsp_d_err", 32'(bus.o_d_err), 32'(aborted));
            chk("rsp_d_rdata", bus.o_d_rdata, erd);
        end else begin
            chk("rsp_if_err", 32'(bus.o_if_err), 32'(aborted));
            chk("rsp_if_rdata", bus.o_if_rdata, erd);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_req"}, 32'(bus.o_mem_req), 32'(0));
        chk({tag, "_mem_addr"}, bus.o_mem_addr, 32'(0));
        chk({tag, "_mem_wen"}, 32'(bus.o_mem_wen), 32'(0));
        chk({tag, "_mem_wdata"}, bus.o_mem_wdata, 32'(0));
        chk({tag, "_mem_mask"}, 32'(bus.o_mem_mask), 32'(0));
        chk({tag, "_acks"}, 32'({bus.o_if_ack, bus.o_d_ack}), 32'(0));
        chk({tag, "_rvalids"}, 32'({bus.o_if_rvalid, bus.o_d_rvalid}), 32'(0));
        chk({tag, "_errs"}, 32'({bus.o_if_err, bus.o_d_err}), 32'(0));
        chk({tag, "_if_rdata"}, bus.o_if_rdata, 32'(0));
        chk({tag, "_d_rdata"}, bus.o_d_rdata, 32'(0));
    endtask

    initial begin
        bit g;
        bit exp_seq [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int rdly, vdly;

        bus.i_mem_ready  = 1'b0;
        bus.i_mem_rvalid = 1'b0;
        bus.i_mem_rdata  = '0;
        drive_reqs();

        // reset state
        advance();
        advance();
        #1;
        chk_all_zero("reset");
        advance();
        rst_n = 1'b1;
        #1;

        // single fetch
        if_pend = 1'b1; if_a = 32'h10;
        drive_reqs();
        do_txn(0, 0, 32'hDEADBEEF, 1'b0, 1'b0, g);
        idle(1);

        // simultaneous fetch and data load: data first, fetch acked in the response cycle
        if_pend = 1'b1; if_a = 32'h40;
        d_pend = 1'b1; d_a = 32'h200; d_w = 1'b0; d_wd = 32'h0; d_m = 4'b0011;
        drive_reqs();
        do_txn(0, 0, 32'hCAFE0001, 1'b0, 1'b0, g);
        chk("simul_first_is_data", 32'(g), 32'(1));
        do_txn(0, 0, 32'hCAFE0002, 1'b0, 1'b0, g);
        chk("simul_second_is_fetch", 32'(g), 32'(0));
        idle(1);

        // both requests held: fetch forced through after MAXD data grants
        new_if();
        new_d();
        drive_reqs();
        for (int i = 0; i < 10; i++) begin
            do_txn(0, 0, $urandom, 1'b1, 1'b1, g);
            chk("grant_seq", 32'(g), 32'(exp_seq[i]));
        end
        if_pend = 1'b0; d_pend = 1'b0;
        drive_reqs();
        idle(1);

        // store: exact fields, completion with zero rdata
        d_pend = 1'b1; d_a = 32'h300; d_w = 1'b1; d_wd = 32'h12345678; d_m = 4'hF;
        drive_reqs();
        do_txn(1, 2, 32'hFFFFFFFF, 1'b0, 1'b0, g);
        idle(1);

        // ready never comes: abort after TMO REQ cycles, then a stray rvalid is ignored
        d_pend = 1'b1; d_a = 32'h400; d_w = 1'b0; d_wd = 32'h0; d_m = 4'hF;
        drive_reqs();
        do_txn(int'(TMO), 0, 32'h55555555, 1'b0, 1'b0, g);
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = 32'hBAD0BAD0;
        idle(2);
        bus.i_mem_rvalid = 1'b0;

        // reset while in WAIT
        advance();
        if_pend = 1'b1; if_a = 32'h500;
        drive_reqs();
        #1;
        chk("rst_seq_if_ack", 32'(bus.o_if_ack), 32'(1));
        advance();
        if_pend = 1'b0;
        drive_reqs();
        bus.i_mem_ready = 1'b1;
        #1;
        chk("rst_seq_mem_req", 32'(bus.o_mem_req), 32'(1));
        advance();
        bus.i_mem_ready = 1'b0;
        d_pend = 1'b1; d_a = 32'h600; d_w = 1'b0; d_wd = 32'h0; d_m = 4'b1100;
        drive_reqs();
        #1;
        chk("rst_seq_wait_mem_req", 32'(bus.o_mem_req), 32'(0));
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        advance();
        rst_n = 1'b1;
        m_streak = 0;
        #1;
        chk("after_rst_rvalids", 32'({bus.o_if_rvalid, bus.o_d_rvalid}), 32'(0));
        do_txn(0, 1, 32'h0BADF00D, 1'b0, 1'b0, g);
        idle(1);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            if (!if_pend && !d_pend) begin
                case ($urandom_range(0, 2))
                    0: new_if();
                    1: new_d();
                    default: begin new_if(); new_d(); end
                endcase
            end else if (!if_pend && $urandom_range(0, 1) == 1) begin
                new_if();
            end else if (!d_pend && $urandom_range(0, 1) == 1) begin
                new_d();
            end
            drive_reqs();
            rdly = ($urandom_range(0, 9) == 0) ? int'(TMO) : int'($urandom_range(0, 3));
            vdly = ($urandom_range(0, 9) == 0) ? int'(TMO) : int'($urandom_range(0, 3));
            do_txn(rdly, vdly, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), g);
        end
        if_pend = 1'b0; d_pend = 1'b0;
        drive_reqs();
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name:
mem_port_arbiter

Overview:
Shares one unified single-port memory between the hart's instruction-fetch port and data port, replacing the split imem/dmem banks. Fixed data-first priority with a fetch anti-starvation limit. One outstanding memory transaction at a time, a valid/ready request side, and a timeout abort that returns an error to the owning requester.

Parameters:
MAX_DGRANT, 4, max consecutive data grants while a fetch is pending (>=1)
TIMEOUT, 255, max cycles in REQ or WAIT before abort (>=1)

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_if_req  in  1  fetch request; held with i_if_addr until o_if_ack
i_if_addr  in  32  fetch word address
o_if_ack  out  1  fetch request accepted (combinational, IDLE only)
o_if_rvalid  out  1  fetch response valid, 1-cycle pulse, registered
o_if_rdata  out  32  fetch response data
o_if_err  out  1  fetch aborted by timeout, qualifies o_if_rvalid
i_d_req  in  1  data request; held with fields until o_d_ack
i_d_addr  in  32  data address
i_d_wen  in  1  1=store, 0=load
i_d_wdata  in  32  store data
i_d_mask  in  4  byte mask
o_d_ack  out  1  data request accepted (combinational, IDLE only)
o_d_rvalid  out  1  data response/completion valid, 1-cycle pulse, registered
o_d_rdata  out  32  load data; 0 for stores
o_d_err  out  1  data aborted by timeout, qualifies o_d_rvalid
o_mem_req  out  1  memory request valid
o_mem_addr  out  32  memory address
o_mem_wen  out  1  memory write enable
o_mem_wdata  out  32  memory write data
o_mem_mask  out  4  memory byte mask
i_mem_ready  in  1  memory accepts request when high with o_mem_req
i_mem_rvalid  in  1  memory completion (loads and stores), sampled in WAIT only
i_mem_rdata  in  32  memory read data, valid with i_mem_rvalid

Behaviour:
- Reset (i_rst_n low, async): state IDLE, dcount 0, timer 0, all outputs 0. Reset mid-transaction drops it; no rvalid is issued for it.
- States: IDLE -> REQ -> WAIT -> IDLE.
- IDLE: if any request, grant one. o_x_ack=1 that cycle. Fields are latched into the o_mem_* registers (fetch: wen=0, mask=4'b1111, wdata=0). Owner is recorded. Next state is REQ.
- Grant rule: data wins when i_d_req, unless i_if_req && dcount>=MAX_DGRANT, in which case fetch wins.
- dcount: +1 (saturating) on a data grant with i_if_req high; cleared on a fetch grant or on a data grant with i_if_req low.
- REQ: o_mem_req=1 with fields stable. On i_mem_ready, go to WAIT and drop o_mem_req next cycle.
- WAIT: o_mem_req=0. On i_mem_rvalid, next cycle the owner gets x_rvalid=1 and x_rdata=i_mem_rdata (0 for a store), x_err=0, and state returns to IDLE.
- The response pulse coincides with the first IDLE cycle, so a new grant may be acked that same cycle.
- Timer: cleared on entering REQ or WAIT, +1 per cycle in either state. If it reaches TIMEOUT: return to IDLE, o_mem_req=0, owner gets rvalid=1, err=1, rdata=0.
- A late i_mem_rvalid after abort is ignored (it is not sampled outside WAIT).
- Minimum transaction: ack at cycle 0, REQ at cycle 1 (ready), WAIT at cycle 2 (rvalid), response at cycle 3.
- o_if_ack and o_d_ack are never high together. Never more than one transaction is outstanding.

Test Plan:
- Single fetch, addr 0x10, ready at first REQ cycle, rvalid 1 cycle later with data 0xDEADBEEF -> o_if_ack at c0, o_mem_req c1, o_if_rvalid=1 and o_if_rdata=0xDEADBEEF at c3, o_if_err=0.
- Simultaneous if_req and d_req (load 0x200, mask 0011) -> data acked first and mem_mask=0011; fetch acked in the IDLE cycle where o_d_rvalid pulses.
- d_req and if_req both held high with MAX_DGRANT=4 -> grant sequence D,D,D,D,F,D,D,D,D,F.
- Store 0x300, wdata 0x12345678, mask 1111 -> mem_wen=1 with exact fields; o_d_rvalid pulse with o_d_rdata=0.
- i_mem_ready never asserted, TIMEOUT=8 -> o_mem_req drops after 8 REQ cycles; o_d_rvalid=1, o_d_err=1, o_d_rdata=0; a later stray i_mem_rvalid produces no pulse.
- i_rst_n pulled low while in WAIT -> all outputs 0 immediately; after release, no rvalid and the next request is served normally.
